// File: rtl/envelope_follower.sv
// -----------------------------------------------------------------------------
// envelope_follower
//
// Per-band envelope detector for the vocoder analysis path. Each incoming
// band-pass sample is rectified (with saturation of the most negative code)
// and used to move that band's stored envelope toward it. The envelope rises
// with a fast attack shift and falls with a slow release shift. All bands
// share one two-stage pipeline; the per-band state lives in a register array.
//
// Ports
//   clk_in     : system clock
//   rst_in     : synchronous active-high reset (clears state and pipeline)
//   sample_in  : signed band-pass sample, WIDTH bits
//   band_in    : band index of sample_in
//   valid_in   : sample_in/band_in valid this cycle (no backpressure)
//   env_out    : unsigned envelope of band_out, WIDTH-1 bits
//   band_out   : band index of env_out
//   valid_out  : one-cycle strobe, two cycles after the matching valid_in
// -----------------------------------------------------------------------------
module envelope_follower #(
   parameter int WIDTH         = 24,
   parameter int NUM_BANDS     = 16,
   parameter int ATTACK_SHIFT  = 4,
   parameter int RELEASE_SHIFT = 10
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [WIDTH-1:0]             sample_in,
   input  logic [$clog2(NUM_BANDS)-1:0] band_in,
   input  logic                         valid_in,
   output logic [WIDTH-2:0]             env_out,
   output logic [$clog2(NUM_BANDS)-1:0] band_out,
   output logic                         valid_out
);

   localparam int BW = $clog2(NUM_BANDS);
   localparam int EW = WIDTH - 1;
   localparam logic [EW-1:0] ENV_MAX = {EW{1'b1}};

   // Per-band envelope state
   logic [EW-1:0]        env_mem [NUM_BANDS];
   logic [NUM_BANDS-1:0] band_we;

   // Stage 1 registers
   logic                 s1_valid_reg;
   logic [BW-1:0]        s1_band_reg;
   logic [EW-1:0]        s1_abs_reg;
   logic [EW-1:0]        s1_env_reg;

   // Combinational signals
   logic [WIDTH-1:0]     neg_sample;
   logic [EW-1:0]        abs_value;
   logic [EW-1:0]        env_rd;
   logic signed [WIDTH:0]   diff;
   logic signed [WIDTH:0]   step;
   logic signed [WIDTH+1:0] sum;
   logic [EW-1:0]        env_next;

   // Rectifier: the most negative code has no positive twin, so it saturates.
   // Its negation wraps back to itself, which shows up as the sign bit still set.
   always_comb begin
      neg_sample = '0 - sample_in;
      if (!sample_in[WIDTH-1])
         abs_value = sample_in[EW-1:0];
      else if (neg_sample[WIDTH-1])
         abs_value = ENV_MAX;
      else
         abs_value = neg_sample[EW-1:0];
   end

   // Stage 2 arithmetic. Both operands fit in EW bits, so a WIDTH+1-bit signed
   // difference cannot overflow; the sum gets one more bit for the clamp test.
   always_comb begin
      diff = $signed({2'b00, s1_abs_reg}) - $signed({2'b00, s1_env_reg});
      if (!diff[WIDTH] && (diff != '0))
         step = diff >>> ATTACK_SHIFT;
      else
         step = diff >>> RELEASE_SHIFT;
      sum = $signed({3'b000, s1_env_reg}) + $signed({step[WIDTH], step});
      if (sum[WIDTH+1])
         env_next = '0;
      else if (sum[WIDTH:EW] != '0)
         env_next = ENV_MAX;
      else
         env_next = sum[EW-1:0];
   end

   // Stage 1 read. When stage 2 is about to write the same band, the array
   // still holds the stale value, so take the value being written instead.
   always_comb begin
      if (s1_valid_reg && (s1_band_reg == band_in))
         env_rd = env_next;
      else
         env_rd = env_mem[band_in];
   end

   // One write-enable per band entry
   generate
      for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band_we
         assign band_we[gi] = s1_valid_reg && (s1_band_reg == BW'(gi));
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_BANDS; i++)
            env_mem[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BANDS; i++)
            if (band_we[i])
               env_mem[i] <= env_next;
      end
   end

   // Pipeline and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid_reg <= 1'b0;
         s1_band_reg  <= '0;
         s1_abs_reg   <= '0;
         s1_env_reg   <= '0;
         valid_out    <= 1'b0;
         env_out      <= '0;
         band_out     <= '0;
      end else begin
         s1_valid_reg <= valid_in;
         if (valid_in) begin
            s1_band_reg <= band_in;
            s1_abs_reg  <= abs_value;
            s1_env_reg  <= env_rd;
         end
         valid_out <= s1_valid_reg;
         // Outputs hold their last values between strobes
         if (s1_valid_reg) begin
            env_out  <= env_next;
            band_out <= s1_band_reg;
         end
      end
   end

endmodule

// File: tb/tb_envelope_follower.sv
// -----------------------------------------------------------------------------
// tb_envelope_follower
//
// Directed vector table (attack, forwarding, release, full-scale negative,
// band interleave, reset mid-stream), a sparse-input sequence, then a long
// randomized run. Every cycle's outputs are also compared against a
// behavioural model that keeps one integer envelope per band and applies the
// attack/release rule with floor division.
// -----------------------------------------------------------------------------
module tb_envelope_follower;

   localparam int W   = 24;
   localparam int NB  = 16;
   localparam int BW  = 4;
   localparam int ASH = 4;
   localparam int RSH = 10;
   localparam longint ENV_MAX = (64'sd1 <<< (W - 1)) - 1;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic [W-1:0]  sample_in = '0;
   logic [BW-1:0] band_in = '0;
   logic          valid_in = 1'b0;
   logic [W-2:0]  env_out;
   logic [BW-1:0] band_out;
   logic          valid_out;

   envelope_follower #(
      .WIDTH(W), .NUM_BANDS(NB), .ATTACK_SHIFT(ASH), .RELEASE_SHIFT(RSH)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .sample_in (sample_in),
      .band_in   (band_in),
      .valid_in  (valid_in),
      .env_out   (env_out),
      .band_out  (band_out),
      .valid_out (valid_out)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   longint env_model [NB];
   bit     pend_v    = 1'b0;
   int     pend_band = 0;
   longint pend_env  = 0;
   bit     exp_v     = 1'b0;
   int     exp_band  = 0;
   longint exp_env   = 0;

   typedef struct {
      bit     rst;
      bit     vld;
      int     band;
      longint smp;
      bit     ev;
      int     eb;
      longint ee;
   } vec_t;

   vec_t vec [24];

   function automatic longint floor_div(longint a, longint d);
      longint q;
      q = a / d;
      if ((a % d != 0) && (a < 0))
         q = q - 1;
      return q;
   endfunction

   // Envelope update from the behavioural rules
   function automatic longint model_update(int b, longint raw);
      logic signed [W-1:0] s;
      longint v, a, d, st, e;
      s = raw[W-1:0];
      v = s;
      a = (v < 0) ? -v : v;
      if (a > ENV_MAX) a = ENV_MAX;
      d = a - env_model[b];
      if (d > 0) st = floor_div(d, 64'sd1 <<< ASH);
      else       st = floor_div(d, 64'sd1 <<< RSH);
      e = env_model[b] + st;
      if (e < 0) e = 0;
      if (e > ENV_MAX) e = ENV_MAX;
      env_model[b] = e;
      return e;
   endfunction

   task automatic chk(string name, longint got, longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
      end
   endtask

   // Drive one cycle, then compare outputs with the model after the edge.
   task automatic cycle(bit r, bit v, int b, longint s);
      logic [W-1:0] sv;
      sv        = s[W-1:0];
      rst_in    = r;
      valid_in  = v;
      band_in   = BW'(b);
      sample_in = sv;
      @(posedge clk_in);
      #1;
      cyc++;
      if (r) begin
         for (int i = 0; i < NB; i++) env_model[i] = 0;
         exp_v    = 1'b0;
         exp_band = 0;
         exp_env  = 0;
         pend_v   = 1'b0;
      end else begin
         exp_v = pend_v;
         if (pend_v) begin
            exp_env  = pend_env;
            exp_band = pend_band;
         end
         pend_v = v;
         if (v) begin
            pend_env  = model_update(b, s);
            pend_band = b;
         end
      end
      chk("model_valid", longint'(valid_out), longint'(exp_v));
      chk("model_env",   longint'(env_out),   exp_env);
      chk("model_band",  longint'(band_out),  longint'(exp_band));
      if (valid_out)
         $display("txn cycle %0d band %0d env %h", cyc, band_out, env_out);
   endtask

   task automatic chk_out(string tag, bit ev, int eb, longint ee);
      chk({tag, "_valid"}, longint'(valid_out), longint'(ev));
      chk({tag, "_env"},   longint'(env_out),   ee);
      chk({tag, "_band"},  longint'(band_out),  longint'(eb));
   endtask

   initial begin
      for (int i = 0; i < NB; i++) env_model[i] = 0;

      //          rst  vld  band smp        ev   eb  ee
      vec[0]  = '{1'b1, 1'b0, 0, 64'h000000, 1'b0, 0, 64'h000000};
      vec[1]  = '{1'b0, 1'b1, 3, 64'h100000, 1'b0, 0, 64'h000000};
      vec[2]  = '{1'b0, 1'b1, 3, 64'h100000, 1'b1, 3, 64'h010000};
      vec[3]  = '{1'b0, 1'b1, 3, 64'h000000, 1'b1, 3, 64'h01F000};
      vec[4]  = '{1'b0, 1'b1, 3, 64'hFFFFFF, 1'b1, 3, 64'h01EF84};
      vec[5]  = '{1'b0, 1'b0, 0, 64'h000000, 1'b1, 3, 64'h01EF08};
      vec[6]  = '{1'b0, 1'b0, 0, 64'h000000, 1'b0, 3, 64'h01EF08};
      vec[7]  = '{1'b1, 1'b0, 0, 64'h000000, 1'b0, 0, 64'h000000};
      vec[8]  = '{1'b0, 1'b1, 0, 64'h800000, 1'b0, 0, 64'h000000};
      vec[9]  = '{1'b0, 1'b0, 0, 64'h000000, 1'b1, 0, 64'h07FFFF};
      vec[10] = '{1'b0, 1'b1, 1, 64'h400000, 1'b0, 0, 64'h07FFFF};
      vec[11] = '{1'b0, 1'b1, 2, 64'h000000, 1'b1, 1, 64'h040000};
      vec[12] = '{1'b0, 1'b1, 1, 64'h400000, 1'b1, 2, 64'h000000};
      vec[13] = '{1'b0, 1'b1, 2, 64'h000000, 1'b1, 1, 64'h07C000};
      vec[14] = '{1'b0, 1'b1, 1, 64'h400000, 1'b1, 2, 64'h000000};
      vec[15] = '{1'b0, 1'b1, 2, 64'h000000, 1'b1, 1, 64'h0B4400};
      vec[16] = '{1'b0, 1'b1, 1, 64'h400000, 1'b1, 2, 64'h000000};
      vec[17] = '{1'b0, 1'b1, 2, 64'h000000, 1'b1, 1, 64'h0E8FC0};
      vec[18] = '{1'b0, 1'b0, 0, 64'h000000, 1'b1, 2, 64'h000000};
      vec[19] = '{1'b0, 1'b1, 3, 64'h100000, 1'b0, 2, 64'h000000};
      vec[20] = '{1'b0, 1'b1, 5, 64'h100000, 1'b1, 3, 64'h010000};
      vec[21] = '{1'b1, 1'b1, 3, 64'h100000, 1'b0, 0, 64'h000000};
      vec[22] = '{1'b0, 1'b1, 3, 64'h100000, 1'b0, 0, 64'h000000};
      vec[23] = '{1'b0, 1'b0, 0, 64'h000000, 1'b1, 3, 64'h010000};

      for (int i = 0; i < 24; i++) begin
         cycle(vec[i].rst, vec[i].vld, vec[i].band, vec[i].smp);
         chk_out($sformatf("vec%0d", i), vec[i].ev, vec[i].eb, vec[i].ee);
      end

      // Sparse input: a 20-cycle gap leaves outputs and state untouched
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0, 0, 0);
         chk_out("gap", 1'b0, 3, 64'h010000);
      end
      cycle(1'b0, 1'b1, 3, 64'h100000);
      chk_out("resume_wait", 1'b0, 3, 64'h010000);
      cycle(1'b0, 1'b0, 0, 0);
      chk_out("resume", 1'b1, 3, 64'h01F000);

      // Randomized traffic; a narrow band set half the time to stress forwarding
      for (int i = 0; i < 3000; i++) begin
         bit     r, v;
         int     b;
         longint s;
         int     mode;
         r    = ($urandom_range(0, 299) == 0);
         v    = ($urandom_range(0, 3) != 0);
         b    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1))
                                            : int'($urandom_range(0, NB - 1));
         mode = int'($urandom_range(0, 5));
         case (mode)
            0:       s = 64'h800000;
            1:       s = 64'h7FFFFF;
            2:       s = longint'($urandom_range(0, 40));
            3:       s = -longint'($urandom_range(0, 40));
            default: s = longint'($urandom);
         endcase
         cycle(r, v, b, s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
